// File: rtl/trisc_pkg.sv
// Shared definitions for the TRISC memory arbiter: FSM encoding, requester IDs
// and default bus widths.
package trisc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ADDR   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_ACK    = 2'd3
    } arb_state_t;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_LD  = 1'b1;

    localparam int DEFAULT_AW = 4;
    localparam int DEFAULT_DW = 8;

endpackage

// File: rtl/trisc_rr_pick.sv
// Two-way round-robin pick: a lone requester always wins, a tie goes to the
// side that was not granted last.
module trisc_rr_pick
    import trisc_pkg::*;
(
    input  logic req_cpu,
    input  logic req_ld,
    input  logic last_grant,
    output logic winner,
    output logic valid
);

    always_comb begin
        valid  = req_cpu | req_ld;
        winner = REQ_CPU;
        if (req_cpu && req_ld) begin
            winner = ~last_grant;
        end else if (req_ld) begin
            winner = REQ_LD;
        end
    end

endmodule

// File: rtl/trisc_mem_arbiter.sv
// Arbitrates the CPU control FSM and the program loader onto one shared memory
// port: IDLE -> ADDR -> ACCESS -> ACK, with back-to-back grants from ACK.
module trisc_mem_arbiter
    import trisc_pkg::*;
#(
    parameter int AW = DEFAULT_AW,
    parameter int DW = DEFAULT_DW
) (
    input  logic          SysClock,
    input  logic          Reset,
    input  logic          CpuReq,
    input  logic          CpuWE,
    input  logic [AW-1:0] CpuAddr,
    input  logic [DW-1:0] CpuWData,
    input  logic          LdReq,
    input  logic          LdWE,
    input  logic [AW-1:0] LdAddr,
    input  logic [DW-1:0] LdWData,
    output logic          CpuAck,
    output logic          LdAck,
    output logic [DW-1:0] RdData,
    output logic [AW-1:0] MemAddr,
    output logic          MemAddrLoad,
    output logic          MemWE,
    output logic [DW-1:0] MemWData,
    input  logic [DW-1:0] MemRdData,
    output logic          Busy
);

    arb_state_t    state_reg, state_next;
    logic [AW-1:0] addr_reg;
    logic          we_reg;
    logic [DW-1:0] wdata_reg;
    logic          winner_reg;
    logic          last_grant_reg;
    logic [DW-1:0] rd_data_reg;

    logic [1:0]    req_vec;
    logic [1:0]    req_eff;
    logic [1:0]    ack_vec;
    logic          pick_winner;
    logic          pick_valid;
    logic          latch_en;
    logic          capture_en;
    logic          ack_valid;

    assign req_vec[REQ_CPU] = CpuReq;
    assign req_vec[REQ_LD]  = LdReq;

    // The requester being acked this cycle is masked so the other side gets
    // the next slot without passing through IDLE.
    for (genvar gi = 0; gi < 2; gi++) begin : g_req
        assign req_eff[gi] = req_vec[gi] && !(state_reg == ST_ACK && winner_reg == 1'(gi));
        assign ack_vec[gi] = ack_valid && (winner_reg == 1'(gi));
    end

    trisc_rr_pick u_pick (
        .req_cpu    (req_eff[REQ_CPU]),
        .req_ld     (req_eff[REQ_LD]),
        .last_grant (last_grant_reg),
        .winner     (pick_winner),
        .valid      (pick_valid)
    );

    always_comb begin
        state_next  = state_reg;
        latch_en    = 1'b0;
        capture_en  = 1'b0;
        ack_valid   = 1'b0;
        MemAddr     = '0;
        MemAddrLoad = 1'b0;
        MemWE       = 1'b0;
        MemWData    = '0;
        Busy        = 1'b1;
        case (state_reg)
            ST_IDLE: begin
                Busy = 1'b0;
                if (pick_valid) begin
                    latch_en   = 1'b1;
                    state_next = ST_ADDR;
                end
            end
            ST_ADDR: begin
                MemAddrLoad = 1'b1;
                MemAddr     = addr_reg;
                state_next  = ST_ACCESS;
            end
            ST_ACCESS: begin
                MemAddr    = addr_reg;
                MemWE      = we_reg;
                MemWData   = wdata_reg;
                capture_en = !we_reg;
                state_next = ST_ACK;
            end
            ST_ACK: begin
                ack_valid = 1'b1;
                if (pick_valid) begin
                    latch_en   = 1'b1;
                    state_next = ST_ADDR;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                Busy       = 1'b0;
                state_next = ST_IDLE;
            end
        endcase
    end

    assign CpuAck = ack_vec[REQ_CPU];
    assign LdAck  = ack_vec[REQ_LD];
    assign RdData = rd_data_reg;

    always_ff @(posedge SysClock or posedge Reset) begin
        if (Reset) begin
            state_reg      <= ST_IDLE;
            addr_reg       <= '0;
            we_reg         <= 1'b0;
            wdata_reg      <= '0;
            winner_reg     <= REQ_CPU;
            last_grant_reg <= REQ_LD;
            rd_data_reg    <= '0;
        end else begin
            state_reg <= state_next;
            if (latch_en) begin
                winner_reg     <= pick_winner;
                last_grant_reg <= pick_winner;
                addr_reg       <= (pick_winner == REQ_LD) ? LdAddr   : CpuAddr;
                we_reg         <= (pick_winner == REQ_LD) ? LdWE     : CpuWE;
                wdata_reg      <= (pick_winner == REQ_LD) ? LdWData  : CpuWData;
            end
            if (capture_en) begin
                rd_data_reg <= MemRdData;
            end
        end
    end

endmodule

// File: tb/tb_trisc_mem_arbiter.sv
// Scoreboard bench for trisc_mem_arbiter: a small shared-memory model on the
// Mem* port, two requester drivers, and an ack monitor popping expectations.
module tb_trisc_mem_arbiter;
    import trisc_pkg::*;

    localparam int AW = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          Reset = 1'b1;
    logic          CpuReq = 1'b0, CpuWE = 1'b0, LdReq = 1'b0, LdWE = 1'b0;
    logic [AW-1:0] CpuAddr = '0, LdAddr = '0;
    logic [DW-1:0] CpuWData = '0, LdWData = '0;
    logic          CpuAck, LdAck, MemAddrLoad, MemWE, Busy;
    logic [DW-1:0] RdData, MemWData, MemRdData;
    logic [AW-1:0] MemAddr;

    always #5 clk = ~clk;

    trisc_mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .SysClock    (clk),
        .Reset       (Reset),
        .CpuReq      (CpuReq),
        .CpuWE       (CpuWE),
        .CpuAddr     (CpuAddr),
        .CpuWData    (CpuWData),
        .LdReq       (LdReq),
        .LdWE        (LdWE),
        .LdAddr      (LdAddr),
        .LdWData     (LdWData),
        .CpuAck      (CpuAck),
        .LdAck       (LdAck),
        .RdData      (RdData),
        .MemAddr     (MemAddr),
        .MemAddrLoad (MemAddrLoad),
        .MemWE       (MemWE),
        .MemWData    (MemWData),
        .MemRdData   (MemRdData),
        .Busy        (Busy)
    );

    function automatic logic [7:0] pat(input int i);
        return 8'(i * 37 + 11);
    endfunction

    // Shared memory: address register loaded on MemAddrLoad, write on MemWE.
    logic          seed_mem = 1'b1;
    logic [DW-1:0] mem [16];
    logic [AW-1:0] mar;
    always @(posedge clk) begin
        if (seed_mem) begin
            for (int i = 0; i < 16; i++) mem[i] <= pat(i);
            mar <= '0;
        end else begin
            if (MemAddrLoad) mar <= MemAddr;
            if (MemWE) mem[MemAddr] <= MemWData;
        end
    end
    assign MemRdData = mem[mar];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic       who;
        logic       is_rd;
        logic [7:0] rdata;
        int         due;
    } exp_t;
    typedef struct {
        logic       we;
        logic [3:0] a;
        logic [7:0] d;
    } tx_t;

    exp_t       sb_q[$];
    tx_t        cpu_pend[$];
    tx_t        ld_pend[$];
    logic [7:0] ref_mem [16];
    int         n_checks = 0;
    int         n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
    endtask

    // Queue a transaction for one side and its expected completion, in service order.
    task automatic add_tx(input logic who, input logic we, input logic [3:0] a,
                          input logic [7:0] d, input int due);
        tx_t  t;
        exp_t e;
        t.we = we; t.a = a; t.d = d;
        if (who == REQ_LD) ld_pend.push_back(t);
        else cpu_pend.push_back(t);
        e.who = who; e.is_rd = !we; e.rdata = ref_mem[a]; e.due = due;
        if (we) ref_mem[a] = d;
        sb_q.push_back(e);
    endtask

    task automatic issue_cpu();
        tx_t t = cpu_pend.pop_front();
        CpuWE = t.we; CpuAddr = t.a; CpuWData = t.d; CpuReq = 1'b1;
    endtask

    task automatic issue_ld();
        tx_t t = ld_pend.pop_front();
        LdWE = t.we; LdAddr = t.a; LdWData = t.d; LdReq = 1'b1;
    endtask

    // Requesters present their next queued transaction on Ack, else drop Req.
    task automatic serve(input int budget);
        int n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
            if (CpuAck) begin
                if (cpu_pend.size() != 0) issue_cpu();
                else CpuReq = 1'b0;
            end
            if (LdAck) begin
                if (ld_pend.size() != 0) issue_ld();
                else LdReq = 1'b0;
            end
        end
        #1;
        check("drain", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic check_reset_outputs();
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_cpuack", 32'(CpuAck), 32'd0);
        check("rst_ldack", 32'(LdAck), 32'd0);
        check("rst_memwe", 32'(MemWE), 32'd0);
        check("rst_memaddrload", 32'(MemAddrLoad), 32'd0);
        check("rst_memaddr", 32'(MemAddr), 32'd0);
        check("rst_memwdata", 32'(MemWData), 32'd0);
        check("rst_rddata", 32'(RdData), 32'd0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!Reset && (CpuAck || LdAck)) begin
            check("ack_exclusive", 32'(CpuAck & LdAck), 32'd0);
            if (sb_q.size() == 0) begin
                check("spurious_ack", {30'd0, CpuAck, LdAck}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("ack_who", 32'(LdAck), 32'(e.who));
                if (e.is_rd) check("rd_data", 32'(RdData), 32'(e.rdata));
                if (e.due != 0) check("ack_cycle", 32'(cyc), 32'(e.due));
                $display("ack %s cyc=%0d rd=%0d rddata=%02h", LdAck ? "LD " : "CPU", cyc, e.is_rd, RdData);
            end
        end
    end

    initial begin
        int c;
        for (int i = 0; i < 16; i++) ref_mem[i] = pat(i);

        repeat (3) @(negedge clk);
        check_reset_outputs();
        seed_mem = 1'b0;
        @(negedge clk);
        Reset = 1'b0;

        // CPU write 3 <= A5, cycle-by-cycle
        @(negedge clk);
        c = cyc;
        add_tx(REQ_CPU, 1'b1, 4'h3, 8'hA5, c + 3);
        issue_cpu();
        @(negedge clk);
        check("w_addrload_c1", 32'(MemAddrLoad), 32'd1);
        check("w_addr_c1", 32'(MemAddr), 32'h3);
        check("w_memwe_c1", 32'(MemWE), 32'd0);
        @(negedge clk);
        check("w_memwe_c2", 32'(MemWE), 32'd1);
        check("w_addr_c2", 32'(MemAddr), 32'h3);
        check("w_wdata_c2", 32'(MemWData), 32'hA5);
        check("w_addrload_c2", 32'(MemAddrLoad), 32'd0);
        serve(10);
        @(negedge clk);
        check("w_idle_after", 32'(Busy), 32'd0);

        // Loader reads back address 3 (lone requester, LastGrant = CPU)
        c = cyc;
        add_tx(REQ_LD, 1'b0, 4'h3, 8'h00, c + 3);
        issue_ld();
        serve(10);

        // Reset clears RdData and restores LastGrant = Ld
        @(negedge clk);
        Reset = 1'b1;
        #1;
        check_reset_outputs();
        @(negedge clk);
        Reset = 1'b0;

        // Simultaneous requests: CPU first, Ld straight after with no IDLE
        @(negedge clk);
        c = cyc;
        add_tx(REQ_CPU, 1'b1, 4'h1, 8'h11, c + 3);
        add_tx(REQ_LD, 1'b0, 4'h1, 8'h00, c + 6);
        issue_cpu();
        issue_ld();
        serve(20);

        // Both held for six transactions: strict alternation
        @(negedge clk);
        c = cyc;
        add_tx(REQ_CPU, 1'b1, 4'h7, 8'h3C, c + 3);
        add_tx(REQ_LD, 1'b0, 4'h7, 8'h00, c + 6);
        add_tx(REQ_CPU, 1'b0, 4'h3, 8'h00, c + 9);
        add_tx(REQ_LD, 1'b1, 4'h9, 8'h5A, c + 12);
        add_tx(REQ_CPU, 1'b0, 4'h9, 8'h00, c + 15);
        add_tx(REQ_LD, 1'b0, 4'h0, 8'h00, c + 18);
        issue_cpu();
        issue_ld();
        serve(40);
        @(negedge clk);
        check("alt_idle_after", 32'(Busy), 32'd0);

        // Reset during ACCESS of a write to 5: aborted, no Ack, memory intact
        c = cyc;
        CpuWE = 1'b1; CpuAddr = 4'h5; CpuWData = 8'hEE; CpuReq = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("abort_in_access", 32'(MemWE), 32'd1);
        #1;
        Reset = 1'b1;
        #1;
        check("abort_busy", 32'(Busy), 32'd0);
        check("abort_memwe", 32'(MemWE), 32'd0);
        check("abort_cpuack", 32'(CpuAck), 32'd0);
        CpuReq = 1'b0;
        @(negedge clk);
        check("abort_mem5", 32'(mem[5]), 32'(ref_mem[5]));
        Reset = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_mem5_later", 32'(mem[5]), 32'(ref_mem[5]));
        check("abort_idle", 32'(Busy), 32'd0);

        // CpuReq dropped during ADDR: transaction still completes
        c = cyc;
        add_tx(REQ_CPU, 1'b0, 4'h5, 8'h00, c + 3);
        issue_cpu();
        @(negedge clk);
        check("drop_addrload", 32'(MemAddrLoad), 32'd1);
        CpuReq = 1'b0;
        serve(10);
        @(negedge clk);
        check("drop_idle", 32'(Busy), 32'd0);
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
